// File: rtl/missle_pkg.sv
// ============================================================================
// Module   : missle_pkg
// Purpose  : Shared coordinate width, default flight limits and slot state
//            encoding for the missile pool.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package missle_pkg;

  localparam int COORD_W   = 12;
  localparam int Y_MIN_DEF = 80;
  localparam int Y_MAX_DEF = 704;

  typedef enum logic [0:0] {
    FREE = 1'b0,
    FLY  = 1'b1
  } slot_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/missle_slot.sv
// ============================================================================
// Module   : missle_slot
// Purpose  : One missile: launched at Y_MAX with a latched x, climbs STEP
//            pixels per tick, retires at the top limit or on a hit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module missle_slot
  import missle_pkg::*;
#(
  parameter int Y_MIN = Y_MIN_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int STEP  = 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               launch,
  input  logic [COORD_W-1:0] launch_x,
  input  logic               tick,
  input  logic               hit,
  output logic               on,
  output logic [COORD_W-1:0] ypos,
  output logic [COORD_W-1:0] xpos
);

  localparam logic [COORD_W-1:0] YMAX_C  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] CLEAR_C = COORD_W'(Y_MIN + STEP);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);

  slot_state_e        state_q, state_d;
  logic [COORD_W-1:0] ypos_q, ypos_d;
  logic [COORD_W-1:0] xpos_q, xpos_d;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= FREE;
      ypos_q  <= YMAX_C;
      xpos_q  <= '0;
    end else begin
      state_q <= state_d;
      ypos_q  <= ypos_d;
      xpos_q  <= xpos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ypos_d  = ypos_q;
    xpos_d  = xpos_q;
    case (state_q)
      FREE: begin
        if (launch) begin
          state_d = FLY;
          ypos_d  = YMAX_C;
          xpos_d  = launch_x;
        end
      end
      FLY: begin
        if (hit) begin
          state_d = FREE;
          ypos_d  = YMAX_C;
        end else if (tick) begin
          // Retire before the subtraction could take ypos under Y_MIN.
          if (ypos_q <= CLEAR_C) begin
            state_d = FREE;
            ypos_d  = YMAX_C;
          end else begin
            ypos_d = ypos_q - STEP_C;
          end
        end
      end
      default: state_d = FREE;
    endcase
  end

  assign on   = (state_q == FLY);
  assign ypos = ypos_q;
  assign xpos = xpos_q;

endmodule

`default_nettype wire

// File: rtl/missle_pool_ctl.sv
// ============================================================================
// Module   : missle_pool_ctl
// Purpose  : Pool of N_MISSLES missile slots with fire arbitration, cooldown
//            and a shared movement tick. Define MISSLE_AUTOFIRE_EN for
//            repeat fire while the button is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module missle_pool_ctl
  import missle_pkg::*;
#(
  parameter int N_MISSLES     = 4,
  parameter int COUNTER_LIMIT = 90000,
  parameter int STEP          = 1,
  parameter int Y_MIN         = Y_MIN_DEF,
  parameter int Y_MAX         = Y_MAX_DEF,
  parameter int COOLDOWN      = 16
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         missle_button,
  input  logic [COORD_W-1:0]           player_xpos,
  input  logic [N_MISSLES-1:0]         hit,
  output logic [COORD_W*N_MISSLES-1:0] ypos_out,
  output logic [COORD_W*N_MISSLES-1:0] xpos_out,
  output logic [N_MISSLES-1:0]         on_out,
  output logic                         fire_ack,
  output logic                         fire_drop,
  output logic [3:0]                   active_cnt
);

  localparam int CNT_W = (COUNTER_LIMIT > 0) ? $clog2(COUNTER_LIMIT + 1) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(COUNTER_LIMIT);
  localparam logic [CD_W-1:0]  COOLDOWN_C = CD_W'(COOLDOWN);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 btn_q;
  logic                 arm_q, arm_d;
  logic                 ack_q, drop_q;
  logic [3:0]           act_q;
  logic                 tick;
  logic                 req;
  logic                 any_free;
  logic                 accept;
  logic                 refuse;
  logic                 sel_found;
  logic [N_MISSLES-1:0] launch;
`ifdef MISSLE_AUTOFIRE_EN
  logic                 dropped_q, dropped_d;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      cd_q   <= '0;
      btn_q  <= 1'b0;
      arm_q  <= 1'b0;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      act_q  <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      cd_q   <= cd_d;
      btn_q  <= missle_button;
      arm_q  <= arm_d;
      ack_q  <= accept;
      drop_q <= refuse;
      act_q  <= popcount8(8'(on_out));
    end
  end

`ifdef MISSLE_AUTOFIRE_EN
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= dropped_d;
    end
  end
`endif

  always_comb begin
    tick  = (cnt_q == LIMIT_C);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    // A button still held across reset must be released once before it counts.
    arm_d = arm_q | ~missle_button;
`ifdef MISSLE_AUTOFIRE_EN
    req = missle_button & arm_q;
`else
    req = missle_button & ~btn_q & arm_q;
`endif
    any_free = ~&on_out;
    accept   = req && (cd_q == '0) && any_free;
`ifdef MISSLE_AUTOFIRE_EN
    refuse    = req && (cd_q == '0) && !any_free && !dropped_q;
    dropped_d = missle_button & (dropped_q | refuse) & ~accept;
`else
    refuse = req && (cd_q == '0) && !any_free;
`endif
    if (accept) begin
      cd_d = COOLDOWN_C;
    end else if (cd_q != '0) begin
      cd_d = cd_q - 1'b1;
    end else begin
      cd_d = cd_q;
    end
    launch    = '0;
    sel_found = 1'b0;
    for (int i = 0; i < N_MISSLES; i++) begin
      if (!sel_found && !on_out[i]) begin
        launch[i] = accept;
        sel_found = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_MISSLES; gi++) begin : g_slot
      missle_slot #(
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX),
        .STEP  (STEP)
      ) u_slot (
        .pclk     (pclk),
        .rst      (rst),
        .launch   (launch[gi]),
        .launch_x (player_xpos),
        .tick     (tick),
        .hit      (hit[gi]),
        .on       (on_out[gi]),
        .ypos     (ypos_out[COORD_W*gi +: COORD_W]),
        .xpos     (xpos_out[COORD_W*gi +: COORD_W])
      );
    end
  endgenerate

  assign fire_ack   = ack_q;
  assign fire_drop  = drop_q;
  assign active_cnt = act_q;

endmodule

`default_nettype wire

// File: tb/tb_missle_pool_ctl.sv
// ============================================================================
// Module   : tb_missle_pool_ctl
// Purpose  : Self-checking bench for missle_pool_ctl (N=4, LIMIT=3, CD=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_missle_pool_ctl;

  localparam int N = 4;

  logic            pclk;
  logic            rst;
  logic            missle_button;
  logic [11:0]     player_xpos;
  logic [N-1:0]    hit;
  logic [12*N-1:0] ypos_out;
  logic [12*N-1:0] xpos_out;
  logic [N-1:0]    on_out;
  logic            fire_ack;
  logic            fire_drop;
  logic [3:0]      active_cnt;

  typedef struct {
    bit          drop;
    int          slot;
    logic [11:0] x;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   tb_cnt = 0;
  bit   tick_edge = 0;

  missle_pool_ctl #(
    .N_MISSLES     (N),
    .COUNTER_LIMIT (3),
    .STEP          (1),
    .Y_MIN         (80),
    .Y_MAX         (704),
    .COOLDOWN      (2)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .missle_button (missle_button),
    .player_xpos   (player_xpos),
    .hit           (hit),
    .ypos_out      (ypos_out),
    .xpos_out      (xpos_out),
    .on_out        (on_out),
    .fire_ack      (fire_ack),
    .fire_drop     (fire_drop),
    .active_cnt    (active_cnt)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ysl(input int i);
    return ypos_out[12*i +: 12];
  endfunction

  function automatic logic [11:0] xsl(input int i);
    return xpos_out[12*i +: 12];
  endfunction

  task automatic monitor();
    exp_t e;
    if (fire_ack || fire_drop) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {62'd0, fire_ack, fire_drop}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_kind", {63'd0, fire_drop}, {63'd0, e.drop});
        if (e.cyc >= 0) check("sb_cycle", cyc, e.cyc);
        if (!e.drop) begin
          check("sb_on", {63'd0, on_out[e.slot]}, 64'd1);
          check("sb_ypos", {52'd0, ysl(e.slot)}, 64'd704);
          check("sb_xpos", {52'd0, xsl(e.slot)}, {52'd0, e.x});
        end
      end
    end
  endtask

  task automatic step();
    @(posedge pclk);
    tick_edge = rst && (tb_cnt == 3);
    if (rst) tb_cnt = (tb_cnt == 3) ? 0 : tb_cnt + 1;
    cyc++;
    #1;
    monitor();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic expect_ev(input bit drop, input int slot, input logic [11:0] x, input int at);
    exp_t e;
    e.drop = drop;
    e.slot = slot;
    e.x    = x;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic press(input logic [11:0] x, input bit drop, input int slot);
    player_xpos   = x;
    missle_button = 1'b1;
    expect_ev(drop, slot, x, cyc + 1);
    step();
    missle_button = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    tb_cnt = 0;
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int          ticks;
    int          cyc0;
    bit          first;
    bit          done;
    logic [11:0] last_y;
    logic [11:0] y0;

    rst           = 1'b1;
    missle_button = 1'b0;
    player_xpos   = '0;
    hit           = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_on", {60'd0, on_out}, 64'd0);
    check("rst_ypos", {16'd0, ypos_out}, {16'd0, {4{12'd704}}});
    check("rst_xpos", {16'd0, xpos_out}, 64'd0);
    check("rst_ack_drop", {62'd0, fire_ack, fire_drop}, 64'd0);
    check("rst_cnt", {60'd0, active_cnt}, 64'd0);
    repeat (2) @(posedge pclk);
    #1;
    rst    = 1'b1;
    tb_cnt = 0;
    idle(2);

    // Single shot flies from 704 to 81 and retires on the following tick.
    press(12'd100, 1'b0, 0);
    check("s1_cnt_lag", {60'd0, active_cnt}, 64'd0);
    ticks  = 0;
    first  = 1'b1;
    done   = 1'b0;
    last_y = ysl(0);
    for (int k = 0; k < 3000 && !done; k++) begin
      last_y = ysl(0);
      step();
      if (k == 0) check("s1_cnt", {60'd0, active_cnt}, 64'd1);
      if (tick_edge) begin
        ticks++;
        if (first) begin
          check("s1_first_tick", {52'd0, ysl(0)}, 64'd703);
          first = 1'b0;
        end
      end
      if (!on_out[0]) done = 1'b1;
    end
    check("s1_done", {63'd0, done}, 64'd1);
    check("s1_ticks", ticks, 624);
    check("s1_last_y", {52'd0, last_y}, 64'd81);
    check("s1_clear_y", {52'd0, ysl(0)}, 64'd704);
    check("s1_keep_x", {52'd0, xsl(0)}, 64'd100);

    // Five presses: four fill slots in order, the fifth is refused.
    for (int i = 0; i < 5; i++) begin
      press(12'(200 + 10 * i), (i == 4), (i < 4) ? i : 0);
      idle(3);
    end
    check("s2_cnt", {60'd0, active_cnt}, 64'd4);
    check("s2_on", {60'd0, on_out}, 64'hF);
    check("s2_x2", {52'd0, xsl(2)}, 64'd220);

    // Asynchronous reset mid-flight with the button held (press is refused first).
    missle_button = 1'b1;
    expect_ev(1'b1, 0, 12'd0, cyc + 1);
    step();
    #2 rst = 1'b0;
    tb_cnt = 0;
    #1;
    check("ar_on", {60'd0, on_out}, 64'd0);
    check("ar_ypos", {16'd0, ypos_out}, {16'd0, {4{12'd704}}});
    check("ar_xpos", {16'd0, xpos_out}, 64'd0);
    check("ar_cnt", {60'd0, active_cnt}, 64'd0);
    check("ar_ack_drop", {62'd0, fire_ack, fire_drop}, 64'd0);
    check("ar_sb", sb.size(), 0);
    repeat (2) @(posedge pclk);
    #1 rst = 1'b1;
    idle(5);
    check("ar_hold_on", {60'd0, on_out}, 64'd0);
    missle_button = 1'b0;
    idle(2);
    press(12'd300, 1'b0, 0);
    idle(3);

    // Re-press during cooldown is silently ignored.
    press(12'd400, 1'b0, 1);
    step();
    missle_button = 1'b1;
    step();
    missle_button = 1'b0;
    idle(3);
    check("cd_cnt", {60'd0, active_cnt}, 64'd2);
    check("cd_on", {60'd0, on_out}, 64'h3);

    // Hit on slot 1 during a tick cycle; slot 0 still moves.
    for (int k = 0; k < 8 && tb_cnt != 3; k++) step();
    y0  = ysl(0);
    hit = 4'b0010;
    step();
    hit = '0;
    check("hit_on", {60'd0, on_out}, 64'h1);
    check("hit_y1", {52'd0, ysl(1)}, 64'd704);
    check("hit_y0", {52'd0, ysl(0)}, {52'd0, y0} - 64'd1);
    check("hit_x1", {52'd0, xsl(1)}, 64'd400);
    idle(1);
    press(12'd500, 1'b0, 1);
    idle(3);

    // Freed-this-cycle slot is not reused by a simultaneous press.
    press(12'd600, 1'b0, 2);
    idle(3);
    press(12'd610, 1'b0, 3);
    idle(3);
    hit = 4'b0001;
    press(12'd620, 1'b1, 0);
    hit = '0;
    idle(3);
    check("free_cnt", {60'd0, active_cnt}, 64'd3);
    press(12'd630, 1'b0, 0);
    idle(3);
    check("free_on", {60'd0, on_out}, 64'hF);

    // Held button for 12 cycles from an empty pool.
    do_reset();
    idle(2);
    cyc0 = cyc;
    player_xpos   = 12'd700;
    missle_button = 1'b1;
`ifdef MISSLE_AUTOFIRE_EN
    for (int i = 0; i < 4; i++) expect_ev(1'b0, i, 12'd700, cyc0 + 1 + 3 * i);
`else
    expect_ev(1'b0, 0, 12'd700, cyc0 + 1);
`endif
    idle(12);
    missle_button = 1'b0;
    idle(3);
`ifdef MISSLE_AUTOFIRE_EN
    check("hold_cnt", {60'd0, active_cnt}, 64'd4);
`else
    check("hold_cnt", {60'd0, active_cnt}, 64'd1);
`endif

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/missle_pool_ctl.md
MISSLE_POOL_CTL -- requirements
Module: missle_pool_ctl

Interface
REQ-001 SHALL have parameter N_MISSLES, default 4: number of independent missile slots, 1..8.
REQ-002 SHALL have parameter COUNTER_LIMIT, default 90000: pclk cycles per movement tick, minus one.
REQ-003 SHALL have parameter STEP, default 1: pixels moved per tick, 1..15.
REQ-004 SHALL have parameters Y_MIN = 80 and Y_MAX = 704: upper flight limit and launch ypos.
REQ-005 SHALL have parameter COOLDOWN, default 16: cycles blocked after an accepted shot.
REQ-006 SHALL have port pclk, input, 1: the single clock; all state on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port missle_button, input, 1: fire request, synchronous to pclk.
REQ-009 SHALL have port player_xpos, input, 12: ship x latched at launch.
REQ-010 SHALL have port hit, input, N_MISSLES: per-slot collision kill.
REQ-011 SHALL have port ypos_out, output, 12*N_MISSLES: packed per-slot ypos, slot i at bits [12i+11:12i].
REQ-012 SHALL have port xpos_out, output, 12*N_MISSLES: packed latched per-slot xpos.
REQ-013 SHALL have port on_out, output, N_MISSLES: slot active.
REQ-014 SHALL have port fire_ack, output, 1: one-cycle pulse, shot accepted.
REQ-015 SHALL have port fire_drop, output, 1: one-cycle pulse, shot refused because all slots are busy.
REQ-016 SHALL have port active_cnt, output, 4: number of set on_out bits, registered.

Function
REQ-017 SHALL detect a fire request on the rising edge of missle_button, using a registered previous sample.
REQ-018 SHALL accept a request only when cooldown is 0 and at least one slot is free; accepted requests go to the lowest-index free slot.
REQ-019 SHALL, on acceptance, on the next edge set the slot on_out=1, ypos=Y_MAX, xpos=player_xpos, pulse fire_ack, and load the cooldown with COOLDOWN.
REQ-020 SHALL decrement the cooldown by 1 per cycle, saturating at 0.
REQ-021 SHALL ignore requests arriving during cooldown, with no fire_drop.
REQ-022 SHALL, for a request with cooldown 0 and all slots busy, pulse fire_drop and leave state otherwise unchanged.
REQ-023 SHALL run one shared refresh counter from 0 to COUNTER_LIMIT, then wrap to 0; tick is asserted in the cycle the counter equals COUNTER_LIMIT.
REQ-024 SHALL run the refresh counter continuously from reset, independent of slot activity.
REQ-025 SHALL, on tick, for each active slot: if ypos <= Y_MIN+STEP, clear it (on_out=0, ypos=Y_MAX); otherwise ypos -= STEP.
REQ-026 SHALL make ypos never go below Y_MIN and never wrap.
REQ-027 SHALL clear active slot i on the next edge when hit[i]=1; hit has priority over tick.
REQ-028 SHALL ignore hit on inactive slots.
REQ-029 SHALL not reallocate a slot freed in cycle t before cycle t+1; a simultaneous free and fire picks another free slot or drops.
REQ-030 SHALL hold ypos=Y_MAX and keep the last xpos on inactive slots.
REQ-031 SHALL update active_cnt one cycle after the on_out change.

Reset
REQ-032 SHALL, while rst=0, immediately force: on_out=0, ypos=Y_MAX all slots, xpos=0, fire_ack=0, fire_drop=0, active_cnt=0, refresh counter=0, cooldown=0, button history=0.
REQ-033 SHALL, on reset assertion mid-flight, abort all missiles; after release a held button does not fire until released and pressed again.

Configuration
REQ-034 SHALL, with macro MISSLE_AUTOFIRE_EN defined, treat a held missle_button as a request every cycle cooldown reaches 0, giving repeat fire at COOLDOWN+1 cycle spacing; fire_drop then pulses at most once per held-full period.
REQ-035 SHALL, without MISSLE_AUTOFIRE_EN, fire on rising edges only (REQ-017).

Structure
REQ-036 SHALL place in shared package missle_pkg: coordinate width 12, default Y_MIN/Y_MAX, and the slot state encoding (FREE, FLY).
REQ-037 SHALL implement one slot per instance of sub-module missle_slot (inputs: launch, launch_x, tick, hit; outputs: on, ypos, xpos), generated N_MISSLES times; allocation, cooldown, refresh counter and counting stay in the top.

Verification
REQ-038 SHALL cover: N=4, COUNTER_LIMIT=3, COOLDOWN=2, one press at player_xpos=100 -> fire_ack next cycle, slot0 on, ypos 704, xpos 100, ypos 703 after first tick, cleared when ypos reaches 81 and tick occurs.
REQ-039 SHALL cover: 5 presses spaced 4 cycles apart -> slots 0..3 fill in order, 5th gives fire_drop, active_cnt=4.
REQ-040 SHALL cover: press, re-press 1 cycle later -> second ignored (cooldown), no fire_drop.
REQ-041 SHALL cover: slots 0,1 active, hit=2'b10 on a tick cycle -> slot1 cleared, slot0 decremented, next press takes slot1.
REQ-042 SHALL cover: rst=0 asynchronously mid-flight with button held -> all outputs reset values at once; no fire after release until a new edge (autofire off).
REQ-043 SHALL cover: MISSLE_AUTOFIRE_EN with button held 12 cycles, COOLDOWN=2 -> fire_ack at cycles 1, 4, 7, 10.
